fetch_controller: RTL

//  Program-level sequencer for the instruction fetch unit.
//  - Turns the bench Go/Ack handshake into the Start/Halt/Branch controls that fetch consumes.
//  - Flushes wrong-path slots after a taken branch.
//  - Drains the pipeline after a halt instruction.
//  - Counts executed cycles and runs a watchdog timeout.
//  - Sits between top-level bench/decode/execute and the fetch PC register.

---
 rtl/fetch_ctrl_if.sv | 32 +++
 rtl/fetch_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// Handshake/control bundle between the program-level sequencer and its neighbours.
// The slave side is the controller; the master side is bench/decode/execute/fetch.
interface fetch_ctrl_if #(
  parameter int unsigned PC_size = 16,
  parameter int unsigned CNT_W   = 16
);
  logic               Go;
  logic [PC_size-1:0] StartAddress;
  logic               HaltReq;
  logic               BranchReq;
  logic [PC_size-1:0] BranchTarget;
  logic               Start;
  logic [PC_size-1:0] StartPC;
  logic               Halt;
  logic               Branch;
  logic [PC_size-1:0] BranchAddress;
  logic               FetchValid;
  logic               Busy;
  logic               Ack;
  logic               Timeout;
  logic [CNT_W-1:0]   CycleCount;

  modport master (
    output Go, StartAddress, HaltReq, BranchReq, BranchTarget,
    input  Start, StartPC, Halt, Branch, BranchAddress, FetchValid, Busy, Ack, Timeout, CycleCount
  );

  modport slave (
    input  Go, StartAddress, HaltReq, BranchReq, BranchTarget,
    output Start, StartPC, Halt, Branch, BranchAddress, FetchValid, Busy, Ack, Timeout, CycleCount
  );
endinterface

// File: rtl/fetch_controller.sv
// Program-level sequencer for instruction fetch: Go/Ack handshake, branch flush,
// halt drain, saturating cycle counter and watchdog.
module fetch_controller #(
  parameter int unsigned PC_size      = 16,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MAX_CYCLES   = 65535
) (
  input logic         CLK,
  input logic         RSTn,
  fetch_ctrl_if.slave bus
);
  localparam int unsigned      SLOT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [PC_size-1:0] start_pc_q, start_pc_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic               timeout_q, timeout_d;
  logic               start_q, start_d;
  logic               halt_q, halt_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;
  logic               branch_c;
  logic               wd_hit;

  // Next state, counters and registered-output decode of the next state.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    start_pc_d    = start_pc_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    branch_c      = 1'b0;
    wd_hit        = (cycle_count_q == WD_LAST);

    if ((state_q == S_RUN || state_q == S_FLUSH || state_q == S_DRAIN) &&
        cycle_count_q != CNT_SAT) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.Go) begin
          state_d       = S_LOAD;
          start_pc_d    = bus.StartAddress;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        // Watchdog beats halt, halt beats branch.
        if (wd_hit) begin
          state_d   = S_DRAIN;
          slot_d    = SLOT_W'(DRAIN_CYCLES);
          timeout_d = 1'b1;
        end else if (bus.HaltReq) begin
          state_d = S_DRAIN;
          slot_d  = SLOT_W'(DRAIN_CYCLES);
        end else if (bus.BranchReq) begin
          branch_c = 1'b1;
          state_d  = S_FLUSH;
          slot_d   = SLOT_W'(FLUSH_CYCLES);
        end
      end
      S_FLUSH: begin
        // Requests here come from squashed slots and are dropped.
        if (wd_hit) begin
          state_d   = S_DRAIN;
          slot_d    = SLOT_W'(DRAIN_CYCLES);
          timeout_d = 1'b1;
        end else if (slot_q == SLOT_W'(1)) begin
          state_d = S_RUN;
          slot_d  = '0;
        end else begin
          slot_d = slot_q - SLOT_W'(1);
        end
      end
      S_DRAIN: begin
        if (slot_q == SLOT_W'(1)) begin
          state_d = S_DONE;
          slot_d  = '0;
        end else begin
          slot_d = slot_q - SLOT_W'(1);
        end
      end
      S_DONE: begin
        if (!bus.Go) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    start_d       = (state_d == S_LOAD);
    halt_d        = (state_d == S_IDLE) || (state_d == S_DRAIN) || (state_d == S_DONE);
    fetch_valid_d = (state_d == S_RUN);
    busy_d        = (state_d == S_LOAD) || (state_d == S_RUN) ||
                    (state_d == S_FLUSH) || (state_d == S_DRAIN);
    ack_d         = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= S_IDLE;
      slot_q        <= '0;
      start_pc_q    <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      start_q       <= 1'b0;
      halt_q        <= 1'b1;
      fetch_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      start_pc_q    <= start_pc_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      start_q       <= start_d;
      halt_q        <= halt_d;
      fetch_valid_q <= fetch_valid_d;
      busy_q        <= busy_d;
      ack_q         <= ack_d;
    end
  end

  assign bus.Start         = start_q;
  assign bus.StartPC       = start_pc_q;
  assign bus.Halt          = halt_q;
  assign bus.Branch        = branch_c;
  assign bus.BranchAddress = bus.BranchTarget;
  assign bus.FetchValid    = fetch_valid_q;
  assign bus.Busy          = busy_q;
  assign bus.Ack           = ack_q;
  assign bus.Timeout       = timeout_q;
  assign bus.CycleCount    = cycle_count_q;
endmodule
